// File: rtl/spi_readout_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package   : spi_readout_pkg                                          |
// | Purpose   : Shared constants and state encoding for the SPI readout  |
// |             slave and its helpers.                                   |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
package spi_readout_pkg;

  localparam int WORD_BITS = 16;
  localparam int DATA_BITS = 12;
  localparam int TAG_BITS  = 4;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_SHIFT     = 3'd2,
    ST_WAIT_LOAD = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_readout_slave_sync_edge_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : sync_edge_detect                                         |
// | Purpose   : Multi-flop synchroniser for an asynchronous input plus   |
// |             an edge-detect flop producing one-cycle rise/fall pulses.|
// | Ports     : sysclk, rst     - clock, sync active-high reset          |
// |             async_i         - asynchronous input                     |
// |             level_o         - synchronised level (STAGES latency)    |
// |             rise_o, fall_o  - one-cycle edge pulses                  |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module sync_edge_detect #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic sysclk,
  input  logic rst,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  generate
    if (STAGES == 1) begin : g_single
      always_ff @(posedge sysclk) begin
        if (rst) sync_q <= RESET_VAL;
        else     sync_q <= async_i;
      end
    end else begin : g_chain
      always_ff @(posedge sysclk) begin
        if (rst) sync_q <= {STAGES{RESET_VAL}};
        else     sync_q <= {sync_q[STAGES-2:0], async_i};
      end
    end
  endgenerate

  always_ff @(posedge sysclk) begin
    if (rst) prev_q <= RESET_VAL;
    else     prev_q <= sync_q[STAGES-1];
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule
`default_nettype wire

// File: rtl/spi_readout_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : spi_readout_slave                                        |
// | Purpose   : SPI mode-0 slave, MSB first, 16-bit frames. Sends        |
// |             {frame tag, 12-bit sample} on MISO and captures the MOSI |
// |             word. Oversamples SPI pins in the sysclk domain.         |
// | Ports     : sysclk, rst            - clock, sync active-high reset   |
// |             spi_sclk/ss_n/mosi     - asynchronous SPI inputs         |
// |             spi_miso               - SPI data out                    |
// |             tx_data                - sample to send (buffer output)  |
// |             spi_ss_sync            - synchronised slave select       |
// |             spi_done, rx_valid     - frame-complete pulses           |
// |             rx_word                - last complete MOSI frame        |
// |             word_cnt               - frames since ss_n fell          |
// |             frame_err              - pulse on aborted frame          |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module spi_readout_slave
  import spi_readout_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int WORD_BITS   = 16,
  parameter int DATA_BITS   = 12
) (
  input  logic                 sysclk,
  input  logic                 rst,
  input  logic                 spi_sclk,
  input  logic                 spi_ss_n,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 spi_ss_sync,
  output logic                 spi_done,
  output logic [WORD_BITS-1:0] rx_word,
  output logic                 rx_valid,
  output logic [15:0]          word_cnt,
  output logic                 frame_err
);

  localparam int             CNT_W    = $clog2(WORD_BITS) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_BITS - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WORD_BITS);

  logic w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall, w_mosi;

  sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .sysclk(sysclk), .rst(rst), .async_i(spi_sclk),
    .level_o(), .rise_o(w_sclk_rise), .fall_o(w_sclk_fall)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .sysclk(sysclk), .rst(rst), .async_i(spi_ss_n),
    .level_o(spi_ss_sync), .rise_o(w_ss_rise), .fall_o(w_ss_fall)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .sysclk(sysclk), .rst(rst), .async_i(spi_mosi),
    .level_o(w_mosi), .rise_o(), .fall_o()
  );

  state_t               state_q;
  logic [CNT_W-1:0]     bit_cnt_q;
  // Holds only the bits still to be sent; the current bit lives in spi_miso_q.
  logic [WORD_BITS-2:0] tx_q;
  logic [WORD_BITS-1:0] rx_q;
  logic [WORD_BITS-1:0] rx_word_q;
  logic [15:0]          word_cnt_q;
  logic                 spi_miso_q, spi_done_q, rx_valid_q, frame_err_q;

  logic [WORD_BITS-1:0] rx_next_d;
  logic [WORD_BITS-1:0] load_word_d;
  logic [WORD_BITS-1:0] done_word_d;

  always_comb begin
    rx_next_d   = {rx_q[WORD_BITS-2:0], w_mosi};
    load_word_d = {word_cnt_q[TAG_BITS-1:0], tx_data};
    // A frame finishing on the same cycle slave-select rises still needs its last bit.
    done_word_d = (state_q == ST_DONE) ? rx_q : rx_next_d;
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      rx_word_q   <= '0;
      word_cnt_q  <= '0;
      spi_miso_q  <= 1'b0;
      spi_done_q  <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      spi_done_q  <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;

      if (w_ss_rise && state_q != ST_IDLE) begin
        state_q    <= ST_IDLE;
        spi_miso_q <= 1'b0;
        bit_cnt_q  <= '0;
        if (state_q == ST_DONE ||
            (state_q == ST_SHIFT && w_sclk_rise && bit_cnt_q == LAST_BIT)) begin
          spi_done_q <= 1'b1;
          rx_valid_q <= 1'b1;
          rx_word_q  <= done_word_d;
          word_cnt_q <= word_cnt_q + 16'd1;
        end else if (bit_cnt_q != '0 && bit_cnt_q <= LAST_BIT) begin
          frame_err_q <= 1'b1;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            spi_miso_q <= 1'b0;
            bit_cnt_q  <= '0;
            if (w_ss_fall) begin
              word_cnt_q <= '0;
              state_q    <= ST_LOAD;
            end
          end
          ST_LOAD: begin
            tx_q       <= load_word_d[WORD_BITS-2:0];
            spi_miso_q <= load_word_d[WORD_BITS-1];
            state_q    <= ST_SHIFT;
          end
          ST_SHIFT: begin
            if (w_sclk_rise) begin
              rx_q      <= rx_next_d;
              bit_cnt_q <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == LAST_BIT) state_q <= ST_DONE;
            end else if (w_sclk_fall && bit_cnt_q != '0 && bit_cnt_q != FULL_CNT) begin
              spi_miso_q <= tx_q[WORD_BITS-2];
              tx_q       <= {tx_q[WORD_BITS-3:0], 1'b0};
            end
          end
          ST_DONE: begin
            spi_done_q <= 1'b1;
            rx_valid_q <= 1'b1;
            rx_word_q  <= rx_q;
            word_cnt_q <= word_cnt_q + 16'd1;
            bit_cnt_q  <= '0;
            state_q    <= ST_WAIT_LOAD;
          end
          ST_WAIT_LOAD: begin
            // Late load gives the address counter and buffer time to present the next sample.
            if (w_sclk_fall) begin
              tx_q       <= load_word_d[WORD_BITS-2:0];
              spi_miso_q <= load_word_d[WORD_BITS-1];
              state_q    <= ST_SHIFT;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign spi_miso  = spi_miso_q;
  assign spi_done  = spi_done_q;
  assign rx_word   = rx_word_q;
  assign rx_valid  = rx_valid_q;
  assign word_cnt  = word_cnt_q;
  assign frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_readout_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tb_spi_readout_slave                                     |
// | Purpose   : Directed self-checking bench for spi_readout_slave.      |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module tb_spi_readout_slave;

  localparam int HALF = 8;

  logic        sysclk = 1'b0;
  logic        rst = 1'b1;
  logic        spi_sclk = 1'b0;
  logic        spi_ss_n = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso;
  logic [11:0] tx_data = 12'h000;
  logic        spi_ss_sync;
  logic        spi_done;
  logic [15:0] rx_word;
  logic        rx_valid;
  logic [15:0] word_cnt;
  logic        frame_err;

  int vecs = 0;
  int errs = 0;
  int n_done = 0;
  int n_valid = 0;
  int n_ferr = 0;

  spi_readout_slave #(.SYNC_STAGES(2), .WORD_BITS(16), .DATA_BITS(12)) dut (
    .sysclk(sysclk), .rst(rst),
    .spi_sclk(spi_sclk), .spi_ss_n(spi_ss_n), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .tx_data(tx_data), .spi_ss_sync(spi_ss_sync),
    .spi_done(spi_done), .rx_word(rx_word), .rx_valid(rx_valid),
    .word_cnt(word_cnt), .frame_err(frame_err)
  );

  always #5 sysclk = ~sysclk;

  always @(negedge sysclk) begin
    if (spi_done)  n_done++;
    if (rx_valid)  n_valid++;
    if (frame_err) n_ferr++;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic ss_start();
    spi_ss_n = 1'b0;
    wait_cyc(HALF);
  endtask

  task automatic ss_end();
    spi_ss_n = 1'b1;
    wait_cyc(HALF);
  endtask

  // One 16-bit frame; MISO sampled just before each rising edge, as the master would.
  task automatic spi_word(input logic [15:0] mo, input logic [11:0] next_tx,
                          output logic [15:0] mi);
    for (int i = 15; i >= 0; i--) begin
      spi_mosi = mo[i];
      wait_cyc(HALF);
      mi[i] = spi_miso;
      spi_sclk = 1'b1;
      if (i == 0) begin
        wait_cyc(6);
        tx_data = next_tx;
        wait_cyc(HALF - 6);
      end else begin
        wait_cyc(HALF);
      end
      spi_sclk = 1'b0;
    end
    wait_cyc(HALF);
  endtask

  task automatic spi_partial(input int nbits);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = i[0];
      wait_cyc(HALF);
      spi_sclk = 1'b1;
      wait_cyc(HALF);
      spi_sclk = 1'b0;
    end
    wait_cyc(HALF);
  endtask

  task automatic test_reset();
    int d0;
    rst = 1'b1;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(1);
    vecs++; if (spi_miso !== 1'b0) begin errs++; $display("FAIL reset_miso got %b exp 0", spi_miso); end
    vecs++; if (spi_ss_sync !== 1'b1) begin errs++; $display("FAIL reset_ss_sync got %b exp 1", spi_ss_sync); end
    vecs++; if ({spi_done, rx_valid, frame_err} !== 3'b000) begin errs++; $display("FAIL reset_pulses got %b exp 000", {spi_done, rx_valid, frame_err}); end
    vecs++; if (word_cnt !== 16'h0000 || rx_word !== 16'h0000) begin errs++; $display("FAIL reset_words got cnt=%h rx=%h exp 0/0", word_cnt, rx_word); end
    d0 = n_done;
    for (int i = 0; i < 4; i++) begin
      spi_sclk = 1'b1; wait_cyc(HALF);
      spi_sclk = 1'b0; wait_cyc(HALF);
    end
    vecs++; if (n_done - d0 !== 0) begin errs++; $display("FAIL idle_sclk_done got %0d exp 0", n_done - d0); end
    vecs++; if (spi_miso !== 1'b0 || word_cnt !== 16'h0 || spi_ss_sync !== 1'b1) begin
      errs++; $display("FAIL idle_sclk_state got miso=%b cnt=%h ss=%b exp 0/0000/1", spi_miso, word_cnt, spi_ss_sync);
    end
  endtask

  task automatic test_single_frame();
    logic [15:0] mi;
    int d0, v0, e0;
    d0 = n_done; v0 = n_valid; e0 = n_ferr;
    tx_data = 12'hABC;
    ss_start();
    vecs++; if (spi_ss_sync !== 1'b0) begin errs++; $display("FAIL single_ss_sync got %b exp 0", spi_ss_sync); end
    spi_word(16'h5A3C, 12'hABC, mi);
    ss_end();
    vecs++; if (mi !== 16'h0ABC) begin errs++; $display("FAIL single_miso got %h exp 0abc", mi); end
    vecs++; if (n_done - d0 !== 1 || n_valid - v0 !== 1) begin errs++; $display("FAIL single_pulses got done=%0d valid=%0d exp 1/1", n_done - d0, n_valid - v0); end
    vecs++; if (rx_word !== 16'h5A3C) begin errs++; $display("FAIL single_rx got %h exp 5a3c", rx_word); end
    vecs++; if (word_cnt !== 16'd1 || n_ferr - e0 !== 0) begin errs++; $display("FAIL single_cnt got cnt=%0d ferr=%0d exp 1/0", word_cnt, n_ferr - e0); end
    vecs++; if (spi_miso !== 1'b0) begin errs++; $display("FAIL single_miso_idle got %b exp 0", spi_miso); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] m0, m1, m2;
    int d0;
    d0 = n_done;
    tx_data = 12'h001;
    ss_start();
    spi_word(16'h1111, 12'h002, m0);
    spi_word(16'h2222, 12'h003, m1);
    spi_word(16'h3333, 12'h003, m2);
    ss_end();
    vecs++; if (m0 !== 16'h0001) begin errs++; $display("FAIL b2b_w0 got %h exp 0001", m0); end
    vecs++; if (m1 !== 16'h1002) begin errs++; $display("FAIL b2b_w1 got %h exp 1002", m1); end
    vecs++; if (m2 !== 16'h2003) begin errs++; $display("FAIL b2b_w2 got %h exp 2003", m2); end
    vecs++; if (n_done - d0 !== 3) begin errs++; $display("FAIL b2b_done got %0d exp 3", n_done - d0); end
    vecs++; if (word_cnt !== 16'd3 || rx_word !== 16'h3333) begin errs++; $display("FAIL b2b_cnt got cnt=%0d rx=%h exp 3/3333", word_cnt, rx_word); end
  endtask

  task automatic test_abort();
    logic [15:0] mi;
    int d0, v0, e0;
    d0 = n_done; v0 = n_valid; e0 = n_ferr;
    tx_data = 12'h5F0;
    ss_start();
    spi_partial(9);
    ss_end();
    vecs++; if (n_ferr - e0 !== 1) begin errs++; $display("FAIL abort_ferr got %0d exp 1", n_ferr - e0); end
    vecs++; if (n_done - d0 !== 0 || n_valid - v0 !== 0) begin errs++; $display("FAIL abort_done got done=%0d valid=%0d exp 0/0", n_done - d0, n_valid - v0); end
    vecs++; if (spi_miso !== 1'b0 || word_cnt !== 16'd0) begin errs++; $display("FAIL abort_idle got miso=%b cnt=%0d exp 0/0", spi_miso, word_cnt); end
    tx_data = 12'h123;
    ss_start();
    spi_word(16'hFFFF, 12'h123, mi);
    ss_end();
    vecs++; if (mi !== 16'h0123) begin errs++; $display("FAIL abort_next_miso got %h exp 0123", mi); end
    vecs++; if (word_cnt !== 16'd1 || rx_word !== 16'hFFFF) begin errs++; $display("FAIL abort_next_cnt got cnt=%0d rx=%h exp 1/ffff", word_cnt, rx_word); end
  endtask

  task automatic test_tag_wrap();
    logic [15:0] mi;
    logic [15:0] exp_w;
    int d0;
    d0 = n_done;
    tx_data = 12'h055;
    ss_start();
    for (int i = 0; i < 17; i++) begin
      spi_word(16'h00FF ^ 16'(i), 12'h055, mi);
      exp_w = {4'(i), 12'h055};
      vecs++; if (mi !== exp_w) begin errs++; $display("FAIL wrap_frame%0d got %h exp %h", i, mi, exp_w); end
    end
    ss_end();
    vecs++; if (word_cnt !== 16'd17 || n_done - d0 !== 17) begin errs++; $display("FAIL wrap_cnt got cnt=%0d done=%0d exp 17/17", word_cnt, n_done - d0); end
    vecs++; if (rx_word !== 16'h00EF) begin errs++; $display("FAIL wrap_rx got %h exp 00ef", rx_word); end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] mi;
    int d0, e0;
    tx_data = 12'h7E5;
    ss_start();
    spi_partial(5);
    d0 = n_done; e0 = n_ferr;
    rst = 1'b1;
    spi_ss_n = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    vecs++; if (spi_miso !== 1'b0 || spi_ss_sync !== 1'b1 || word_cnt !== 16'd0) begin
      errs++; $display("FAIL rstmid_state got miso=%b ss=%b cnt=%0d exp 0/1/0", spi_miso, spi_ss_sync, word_cnt);
    end
    vecs++; if (rx_word !== 16'h0000 || {spi_done, rx_valid, frame_err} !== 3'b000) begin
      errs++; $display("FAIL rstmid_out got rx=%h pulses=%b exp 0000/000", rx_word, {spi_done, rx_valid, frame_err});
    end
    wait_cyc(HALF);
    vecs++; if (n_done - d0 !== 0 || n_ferr - e0 !== 0) begin errs++; $display("FAIL rstmid_pulses got done=%0d ferr=%0d exp 0/0", n_done - d0, n_ferr - e0); end
    ss_start();
    spi_word(16'hC0DE, 12'h7E5, mi);
    ss_end();
    vecs++; if (mi !== 16'h07E5) begin errs++; $display("FAIL rstmid_next_miso got %h exp 07e5", mi); end
    vecs++; if (rx_word !== 16'hC0DE || word_cnt !== 16'd1) begin errs++; $display("FAIL rstmid_next_rx got rx=%h cnt=%0d exp c0de/1", rx_word, word_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_abort();
    test_tag_wrap();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
